// File: rtl/watch_disp_scan.sv
// Six-digit multiplexed seven-segment driver for the stopwatch.
// Re-times the BCD counts, snapshots them once per frame and scans common-anode digits.
module watch_disp_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 83,
  parameter bit LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cnt_m,
  input  logic [7:0] cnt_s,
  input  logic [3:0] cnt_ms,
  input  logic [1:0] key_b,
  input  logic       key3,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [19:0]   bus_s1, bus_s2, snap;
  logic [1:0]    keyb_s1, keyb_s2;
  logic          key3_s1, key3_s2;
  logic [SW-1:0] slot_cnt;
  logic [2:0]    idx;
  logic          pending;
  logic          blink_phase;
  logic [BW-1:0] blink_cnt;

  logic          frame_wrap;
  logic          active;
  logic [3:0]    digit_nib;
  logic [7:0]    digit_code;
  logic [5:0]    lit_sel;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 8'hC0;
      4'd1:    bcd_to_seg = 8'hF9;
      4'd2:    bcd_to_seg = 8'hA4;
      4'd3:    bcd_to_seg = 8'hB0;
      4'd4:    bcd_to_seg = 8'h99;
      4'd5:    bcd_to_seg = 8'h92;
      4'd6:    bcd_to_seg = 8'h82;
      4'd7:    bcd_to_seg = 8'hF8;
      4'd8:    bcd_to_seg = 8'h80;
      4'd9:    bcd_to_seg = 8'h90;
      default: bcd_to_seg = 8'hBF;
    endcase
  endfunction

  assign frame_wrap = (slot_cnt == SLOT_LAST) && (idx == 3'd5);
  assign active     = (keyb_s2 == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_s1  <= '0;
      bus_s2  <= '0;
      keyb_s1 <= '0;
      keyb_s2 <= '0;
      key3_s1 <= 1'b0;
      key3_s2 <= 1'b0;
    end else begin
      bus_s1  <= {cnt_m, cnt_s, cnt_ms};
      bus_s2  <= bus_s1;
      keyb_s1 <= key_b;
      keyb_s2 <= keyb_s1;
      key3_s1 <= key3;
      key3_s2 <= key3_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= 3'd0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Capture only when both sync stages agree, so a half-updated count never reaches the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap    <= '0;
      pending <= 1'b1;
    end else begin
      if (pending && (bus_s1 == bus_s2)) begin
        snap    <= bus_s2;
        pending <= 1'b0;
      end
      if (frame_wrap)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_phase <= 1'b1;
      blink_cnt   <= '0;
    end else if (!key3_s2) begin
      blink_phase <= 1'b1;
      blink_cnt   <= '0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    digit_nib  = 4'h0;
    digit_code = 8'hFF;
    case (idx)
      3'd0: begin
        digit_nib  = snap[19:16];
        digit_code = (LZB && (digit_nib == 4'h0)) ? 8'hFF : bcd_to_seg(digit_nib);
      end
      3'd1: begin
        digit_nib  = snap[15:12];
        digit_code = bcd_to_seg(digit_nib);
      end
      3'd2: begin
        digit_nib  = snap[11:8];
        digit_code = bcd_to_seg(digit_nib);
      end
      3'd3: begin
        digit_nib  = snap[7:4];
        digit_code = bcd_to_seg(digit_nib);
      end
      3'd4: begin
        digit_nib  = snap[3:0];
        digit_code = bcd_to_seg(digit_nib);
      end
      3'd5:    digit_code = (key3_s2 && blink_phase) ? 8'h8C : 8'hFF;
      default: digit_code = 8'hFF;
    endcase
    if ((idx == 3'd1) || (idx == 3'd3))
      digit_code[7] = 1'b0;
    lit_sel = ~(6'b000001 << idx);
  end

  // seg only moves when a digit is lit, so it keeps the previous value through blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else if (!active) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else if (slot_cnt < BLANK_END) begin
      sel <= 6'h3F;
    end else begin
      sel <= lit_sel;
      seg <= digit_code;
    end
  end

endmodule

// File: tb/tb_watch_disp_scan.sv
// Randomized scoreboard bench for watch_disp_scan with a digit-level display model.
// Expected digits are queued by the stimulus thread and consumed by a slot monitor.
module tb_watch_disp_scan;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cnt_m = '0;
  logic [7:0] cnt_s = '0;
  logic [3:0] cnt_ms = '0;
  logic [1:0] key_b = 2'b10;
  logic       key3 = 1'b0;
  logic [5:0] sel;
  logic [7:0] seg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] seg_tbl [10];

  watch_disp_scan #(
    .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF), .LZB(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cnt_m(cnt_m), .cnt_s(cnt_s), .cnt_ms(cnt_ms),
    .key_b(key_b), .key3(key3), .sel(sel), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] s,
                               input logic [3:0] ms, input logic k3);
    cnt_m  = m;
    cnt_s  = s;
    cnt_ms = ms;
    key3   = k3;
  endtask

  // Display model: what each digit position should show for given counts.
  function automatic logic [7:0] ref_seg(input int idx, input logic [7:0] m, input logic [7:0] s,
                                         input logic [3:0] ms, input bit p_visible);
    int nib;
    logic [7:0] c;
    case (idx)
      0:       nib = int'(m) / 16;
      1:       nib = int'(m) % 16;
      2:       nib = int'(s) / 16;
      3:       nib = int'(s) % 16;
      default: nib = int'(ms);
    endcase
    if (idx == 5)                  c = p_visible ? 8'h8C : 8'hFF;
    else if (idx == 0 && nib == 0) c = 8'hFF;
    else if (nib > 9)              c = 8'hBF;
    else                           c = seg_tbl[nib];
    if (idx == 1 || idx == 3) c = c & 8'h7F;
    return c;
  endfunction

  task automatic pushDigit(input int idx, input logic [7:0] v, input string name);
    exp_t e;
    e.idx  = idx;
    e.seg  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic pushFrame(input logic [7:0] m, input logic [7:0] s, input logic [3:0] ms);
    for (int i = 0; i < 6; i++)
      pushDigit(i, ref_seg(i, m, s, ms, 1'b0), $sformatf("digit%0d_m%h_s%h_ms%h", i, m, s, ms));
  endtask

  task automatic waitDrain(input string name, input int budget);
    int t = 0;
    while (exp_q.size() > 0 && t < budget) begin
      tick(1);
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=%0d pending digits required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Expected select pattern for the first frame after reset release (sync warm-up blanks 2 clocks).
  task automatic checkScan(input string name);
    logic [7:0] req;
    int c, ix;
    for (int k = 1; k <= FRAME + 4; k++) begin
      tick(1);
      c  = (k - 1) % SD;
      ix = ((k - 1) / SD) % 6;
      if (k <= 2 || c < BC) req = 8'h3F;
      else                  req = 8'h3F & ~(8'd1 << ix);
      checkOutput($sformatf("%s_sel_k%0d", name, k), {2'b00, sel}, req);
    end
  endtask

  function automatic logic [3:0] rnib();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  logic [5:0] prev_sel = 6'h3F;
  int         mon_lit;
  int         mon_n;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel = 6'h3F;
    end else begin
      if (sel != 6'h3F && prev_sel == 6'h3F) begin
        mon_lit = -1;
        mon_n   = 0;
        for (int i = 0; i < 6; i++)
          if (!sel[i]) begin
            mon_lit = i;
            mon_n++;
          end
        if (mon_n != 1) begin
          checks++;
          failures++;
          $display("[TB] FAIL sel_onehot actual=%h required=one low bit", sel);
        end else if (exp_q.size() > 0 && exp_q[0].idx == mon_lit) begin
          mon_e = exp_q.pop_front();
          checkOutput(mon_e.name, seg, mon_e.seg);
        end
      end
      prev_sel = sel;
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] m, s;
    logic [3:0] ms;
    int t;

    seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    rst_n = 1'b0;
    key_b = 2'b10;
    tick(3);
    checkOutput("reset_sel", {2'b00, sel}, 8'h3F);
    checkOutput("reset_seg", seg, 8'hFF);
    rst_n = 1'b1;
    checkScan("scan");

    applyStimulus(8'h12, 8'h34, 4'h5, 1'b0);
    tick(2 * FRAME + 4);
    pushFrame(8'h12, 8'h34, 4'h5);
    waitDrain("content", 100);

    applyStimulus(8'h07, 8'h5A, 4'h0, 1'b0);
    tick(2 * FRAME + 4);
    pushFrame(8'h07, 8'h5A, 4'h0);
    waitDrain("lzb_dash", 100);

    for (int r = 0; r < 20; r++) begin
      m  = {($urandom_range(0, 3) == 0) ? 4'h0 : rnib(), rnib()};
      s  = {rnib(), rnib()};
      ms = rnib();
      applyStimulus(m, s, ms, 1'b0);
      tick(2 * FRAME + 4);
      pushFrame(m, s, ms);
      waitDrain("random", 100);
    end

    applyStimulus(8'h12, 8'h34, 4'h5, 1'b0);
    tick(2 * FRAME + 4);
    for (int f = 0; f < 2; f++) begin
      pushDigit(2, ref_seg(2, 8'h12, 8'h34, 4'h5, 1'b0), "tear_hold_idx2");
      pushDigit(3, ref_seg(3, 8'h12, 8'h34, 4'h5, 1'b0), "tear_hold_idx3");
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      cnt_s = (i % 2 == 0) ? 8'h59 : 8'h00;
      tick(1);
    end
    cnt_s = 8'h00;
    waitDrain("tear_hold", 100);
    tick(6);
    pushDigit(2, ref_seg(2, 8'h12, 8'h00, 4'h5, 1'b0), "tear_new_idx2");
    pushDigit(3, ref_seg(3, 8'h12, 8'h00, 4'h5, 1'b0), "tear_new_idx3");
    waitDrain("tear_new", FRAME + 4);

    t = 0;
    while (sel != 6'h3E && t < 4 * FRAME) begin
      tick(1);
      t++;
    end
    checkOutput("blink_align_sel", {2'b00, sel}, 8'h3E);
    key3 = 1'b1;
    for (int f = 0; f < 6; f++)
      pushDigit(5, ((f / BF) % 2 == 0) ? 8'h8C : 8'hFF, $sformatf("blink_frame%0d", f));
    waitDrain("blink", 8 * FRAME);
    key3 = 1'b0;
    tick(4);
    pushDigit(5, 8'hFF, "unpaused_a");
    pushDigit(5, 8'hFF, "unpaused_b");
    waitDrain("unpaused", 3 * FRAME);
    key3 = 1'b1;
    tick(4);
    pushDigit(5, 8'h8C, "repause_visible");
    waitDrain("repause", 2 * FRAME);
    key3 = 1'b0;

    tick(7);
    key_b = 2'b01;
    tick(3);
    checkOutput("inactive_sel", {2'b00, sel}, 8'h3F);
    checkOutput("inactive_seg", seg, 8'hFF);
    for (int i = 0; i < FRAME; i++) begin
      tick(1);
      checkOutput($sformatf("inactive_hold_sel%0d", i), {2'b00, sel}, 8'h3F);
    end
    key_b = 2'b10;
    tick(FRAME + 6);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_sel", {2'b00, sel}, 8'h3F);
    checkOutput("midreset_seg", seg, 8'hFF);
    tick(2);
    rst_n = 1'b1;
    checkScan("rescan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_disp_scan.md
# watch_disp_scan

Multiplexed six-digit seven-segment driver for the stopwatch. Consumes the BCD stopwatch counts (minutes, seconds, tenths) and the pause key, re-times them into the system clock domain, takes a tear-free snapshot once per scan frame, and drives common-anode digit selects and segments. It sits directly downstream of the stopwatch counter stage and directly upstream of the board pins.

## Interface
- SCAN_DIV, 50000: system clocks per digit slot (1 ms at 50 MHz); minimum 4.
- BLANK_CYC, 500: clocks at the start of each slot with all selects off (anti-ghosting); must be < SCAN_DIV.
- BLINK_FRAMES, 83: frames per half-period of the pause indicator blink; minimum 1.
- LZB, 1: 1 = blank the minutes tens digit when it is 0.
---
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- cnt_m  input  8  minutes, packed BCD {tens,units}; asynchronous to clk.
- cnt_s  input  8  seconds, packed BCD; asynchronous to clk.
- cnt_ms  input  4  tenths, BCD; asynchronous to clk.
- key_b  input  2  mode; display is active only when key_b == 2'b10.
- key3  input  1  pause key, high = paused; asynchronous.
- sel  output  6  digit selects, active-low; bit 0 is the leftmost digit.
- seg  output  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- Synchronisers: the 20-bit bus {cnt_m,cnt_s,cnt_ms}, key_b and key3 each pass through two flops (s1 -> s2). The bus is "stable" when s1 == s2.
- Snapshot: when a frame starts (digit index wraps 5 -> 0, and once after reset), set `pending`. While pending and the bus is stable, load snap <= s2 and clear pending. If the bus is never stable, the old snap is held indefinitely.
- Digit map, index 0..5: minutes tens, minutes units, seconds tens, seconds units, tenths, status.
- Decimal point is lit on index 1 and index 3.
- Segment codes, before the dp bit is applied: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; any nibble >9 = BF (dash); blank = FF; 'P' = 8C.
- Lighting dp clears bit 7.
- LZB: index 0 shows blank when LZB = 1 and the minutes tens nibble is 0.
- Status digit (index 5):
  - shows 'P' when synced key3 = 1 and the blink phase = 1;
  - otherwise blank.
- Blink phase:
  - toggles after every BLINK_FRAMES complete frames while key3 is high;
  - is forced to 1 and its frame counter cleared whenever key3 is low, so a new pause starts visibly.
- Inactive mode (synced key_b != 2'b10): sel = 6'h3F and seg = 8'hFF. Scanning and snapshot logic keep running.

## Timing
- Slot counter runs 0..SCAN_DIV-1. At the terminal count it wraps and the digit index advances; the index wraps 5 -> 0.
- Frame length = 6*SCAN_DIV clocks.
- sel and seg are registered and reflect the slot counter and index of the previous cycle (1-cycle output latency).
- In each slot, sel = 6'h3F for slot counts 0..BLANK_CYC-1. For the remaining counts, exactly one sel bit (the current index) is low.
- seg is updated on the same edge as sel and holds its value through the blanking interval.
- Input-to-display latency:
  - minimum 2 clocks of sync, then up to 1 frame of snapshot wait, then 1 clock of output register;
  - an input change therefore appears no later than the frame after next, provided the bus is stable.
- Reset (asynchronous):
  - outputs: sel = 6'h3F, seg = 8'hFF;
  - state: slot counter 0, index 0, snap 0, pending = 1, blink phase 1, sync flops 0.
- Reset asserted mid-slot returns to the reset state immediately. After release, scanning restarts at index 0.
- A bus change that coincides with the snapshot edge is not captured, because s1 != s2; the capture retries on the next clock.

## Test plan
Bench parameters: SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
- **Reset and scan:** hold rst_n low, then release with key_b=2'b10. Required: sel=3F and seg=FF during reset. After release, sel steps through 3E, 3D, 3B, 37, 2F, 1F, with each low for 3 of every 4 clocks and 3F for 1 clock.
- **Digit content:** cnt_m=8'h12, cnt_s=8'h34, cnt_ms=4'h5, key3=0, steady. Required from the second frame: seg = F9, 24 (A4 with dp), B0, 19 (99 with dp), 92, FF on indices 0..5.
- **Leading-zero blanking and invalid BCD:** cnt_m=8'h07, cnt_s=8'h5A. Required: index 0 = FF, index 1 = 78, index 3 = 3F (dash with dp).
- **Tear-free snapshot:** toggle cnt_s between 8'h59 and 8'h00 every clock, covering a frame start, then hold it at 8'h00. Required: the snapshot keeps its prior value while toggling. Once the bus is stable, index 2/3 show C0/40 within one frame.
- **Pause blink:** key3=1. Required: index 5 shows 8C for 2 frames, then FF for 2 frames, repeating. When key3=0, index 5 = FF.
- **Mode gating and mid-run reset:** set key_b=2'b01 mid-frame. Required: 3 clocks later, sel=3F and seg=FF. Then return key_b to 2'b10 and pulse rst_n low mid-slot. Required: outputs are immediately 3F/FF, and scanning resumes at index 0.
